weight_tile_fetcher: RTL and testbench
======================================

// Module: weight_tile_fetcher
// PURPOSE
//  Producer end of the weight FIFO that control_unit drains during LOAD_WEIGHTS.
//  Reads 32-row weight tiles from weight SRAM and pushes one row per handshake into the FIFO.
//  Tile order matches the consumer's counting: x outer, y inner, NT = (W_DIM_i>>5)+1 tiles per axis.
//  A 2-entry skid buffer absorbs the SRAM's 1-cycle read latency under backpressure.
// PARAMETERS
//  LANES    32  row width in elements (= systolic array width)
//  DATA_W   8   bits per weight element
//  ADDR_W   16  weight SRAM address width
// PORTS
//  clk_i         in   1              clock; everything is on posedge
//  rst_ni        in   1              reset: asynchronous assert, active-low
//  start_i       in   1              start a fetch job; sampled only in IDLE
//  W_DIM_i       in   9              weight dimension; latched on accepted start
//  base_addr_i   in   ADDR_W         SRAM address of tile (0,0) row 0; latched on start
//  mem_rd_en_o   out  1              SRAM read strobe
//  mem_addr_o    out  ADDR_W         SRAM read address
//  mem_rdata_i   in   LANES*DATA_W   SRAM data, valid exactly 1 cycle after mem_rd_en_o
//  fifo_valid_o  out  1              row available to weight FIFO
//  fifo_data_o   out  LANES*DATA_W   row data
//  fifo_ready_i  in   1              FIFO can accept (i.e. !full)
//  busy_o        out  1              high from accepted start until done_o
//  tile_done_o   out  1              1-cycle pulse on handshake of row 31 of any tile
//  done_o        out  1              1-cycle pulse when the last row of the last tile is handed off
// BEHAVIOUR
//  Reset: every output 0; FSM = IDLE; skid buffer emptied; any in-flight read tag cleared.
//  FSM: IDLE -> FETCH on start_i (busy_o=1 next cycle); FETCH -> DRAIN after last read issued;
//   DRAIN -> IDLE when skid empty and no read in flight; done_o pulses on that transition.
//  start_i while busy_o=1 is ignored; latched W_DIM/base do not change mid-job.
//  Counters: row 5b (0..31), y 4b, x 4b; row wraps -> y++, y==NT-1 wraps -> x++.
//  NT is 5b (1..16): NT = {1'b0,W_DIM[8:5]} + 1. tile_idx = x*NT + y (8b).
//  mem_addr_o = base + {tile_idx, row[4:0]}, truncated to ADDR_W (modulo wrap, no error).
//  Read issue rule: issue in cycle c iff FETCH and (skid_cnt + inflight - pop_c) < 2,
//   with pop_c = fifo_valid_o & fifo_ready_i. This guarantees no skid overflow.
//  Returned data enters the skid tail; fifo_data_o always = skid head; stable while valid & !ready.
//  Latency: start sampled at edge k -> mem_rd_en_o high in cycle k+1 -> fifo_valid_o in k+2.
//  Throughput: with fifo_ready_i held 1, one row per cycle, no bubbles between tiles.
//  Simultaneous push and pop on the skid: count unchanged, order preserved.
//  Reset mid-job: immediate abort, no done_o, data in flight dropped; the next start begins at tile (0,0).
//  Total rows per job = 32*NT*NT; tile_done_o fires NT*NT times, the last one in the same cycle as done_o - 1.
// CONFIGURATION
//  `WEIGHT_FETCH_PERF_EN defined: adds output stall_cycles_o [31:0] = count of cycles with
//   fifo_valid_o=1 & fifo_ready_i=0. Cleared on accepted start and on reset; saturates at 32'hFFFFFFFF.
//  Undefined: port and counter absent; the rest of the behaviour is unchanged.
// TESTING
//  W_DIM=31, base=0x0100, ready=1 -> addrs 0x0100..0x011F consecutive; 32 handshakes; 1 tile_done_o; done_o 1 cycle after last handshake.
//  W_DIM=63, base=0 -> 128 rows; tiles in order idx 0,1,2,3 = (x0,y0),(x0,y1),(x1,y0),(x1,y1); addr of tile (1,0) row 0 = 0x0040.
//  ready low 5 cycles mid-tile -> at most 2 reads outstanding, mem_rd_en_o then stops; fifo_data_o held; no row lost or duplicated.
//  start_i pulsed during a W_DIM=63 job -> ignored; exactly one done_o; row count 128.
//  rst_ni low for 1 cycle at row 40 -> outputs 0 at once; a new start with W_DIM=31 gives addrs from base, row 0.
//  base=0xFFF0, W_DIM=31 -> addrs 0xFFF0..0xFFFF then 0x0000..0x000F; with PERF_EN, 3 stalled cycles -> stall_cycles_o=3.

Source files
------------

// File: rtl/weight_tile_fetcher.sv
// Streams 32-row weight tiles from SRAM to the weight FIFO: rd_en 1 cycle after start, fifo_valid 1 cycle after rd_en.
// Backpressure: a 2-entry skid absorbs the read latency and reads pause while it is full; `WEIGHT_FETCH_PERF_EN adds stall_cycles_o.
module weight_tile_fetcher #(
  parameter int LANES  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [8:0]                W_DIM_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  output logic                      mem_rd_en_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic [LANES*DATA_W-1:0]   mem_rdata_i,
  output logic                      fifo_valid_o,
  output logic [LANES*DATA_W-1:0]   fifo_data_o,
  input  logic                      fifo_ready_i,
  output logic                      busy_o,
  output logic                      tile_done_o,
  output logic                      done_o
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [31:0]               stall_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [4:0]                nt_q, row_q, out_row_q;
  logic [3:0]                x_q, y_q;
  logic [ADDR_W-1:0]         base_q;
  logic                      inflight_q;
  logic [1:0]                skid_cnt_q, skid_cnt_d;
  logic [LANES*DATA_W-1:0]   skid0_q, skid1_q;

  logic       start_acc, pop, y_last, x_last, last_rd, drained;
  logic [7:0] tile_idx;
  logic       unused_wdim_lo;

  assign unused_wdim_lo = ^W_DIM_i[4:0];

  assign start_acc  = (state_q == IDLE) && start_i;
  assign pop        = fifo_valid_o && fifo_ready_i;
  assign y_last     = ({1'b0, y_q} == nt_q - 5'd1);
  assign x_last     = ({1'b0, x_q} == nt_q - 5'd1);
  assign last_rd    = mem_rd_en_o && (row_q == 5'd31) && y_last && x_last;
  assign drained    = (skid_cnt_q == 2'd0) && !inflight_q;
  // Occupancy after this cycle: stored rows plus the returning read minus the one leaving.
  assign skid_cnt_d = skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  assign tile_idx   = 8'({4'b0, x_q} * {3'b0, nt_q}) + {4'b0, y_q};
  assign mem_addr_o = base_q + ADDR_W'({tile_idx, row_q});

  // With nothing stored, returning read data bypasses straight to the FIFO.
  assign fifo_valid_o = (skid_cnt_q != 2'd0) || inflight_q;
  assign fifo_data_o  = ((skid_cnt_q == 2'd0) && inflight_q) ? mem_rdata_i : skid0_q;
  assign tile_done_o  = pop && (out_row_q == 5'd31);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = FETCH;
      FETCH:   if (last_rd) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en_o = (state_q == FETCH) && (skid_cnt_d < 2'd2);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DRAIN) && drained;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nt_q      <= 5'd0;
      base_q    <= '0;
      row_q     <= 5'd0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      out_row_q <= 5'd0;
    end else begin
      if (start_acc) begin
        nt_q      <= {1'b0, W_DIM_i[8:5]} + 5'd1;
        base_q    <= base_addr_i;
        row_q     <= 5'd0;
        x_q       <= 4'd0;
        y_q       <= 4'd0;
        out_row_q <= 5'd0;
      end else begin
        if (mem_rd_en_o) begin
          row_q <= row_q + 5'd1;
          if (row_q == 5'd31) begin
            if (y_last) begin
              y_q <= 4'd0;
              x_q <= x_q + 4'd1;
            end else begin
              y_q <= y_q + 4'd1;
            end
          end
        end
        if (pop) out_row_q <= out_row_q + 5'd1;
      end
    end
  end

  // Entry order is skid0, skid1, then the returning read; the issue rule keeps the total at 2 or less.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      inflight_q <= mem_rd_en_o;
      skid_cnt_q <= skid_cnt_d;
      if (pop) begin
        if (skid_cnt_q == 2'd2)                    skid0_q <= skid1_q;
        else if (skid_cnt_q == 2'd1 && inflight_q) skid0_q <= mem_rdata_i;
      end else if (inflight_q) begin
        if (skid_cnt_q == 2'd0) skid0_q <= mem_rdata_i;
        else                    skid1_q <= mem_rdata_i;
      end
    end
  end

`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                     stall_q <= 32'd0;
    else if (start_acc)                                              stall_q <= 32'd0;
    else if (fifo_valid_o && !fifo_ready_i && stall_q != 32'hFFFFFFFF) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_weight_tile_fetcher.sv
// Directed bench for weight_tile_fetcher: SRAM model returns the read address replicated across the row.
module tb_weight_tile_fetcher;
  localparam int LANES = 32, DATA_W = 8, ADDR_W = 16, DW = LANES * DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [8:0]        W_DIM_i = 9'd0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DW-1:0]     mem_rdata_i = '0;
  logic              fifo_valid_o;
  logic [DW-1:0]     fifo_data_o;
  logic              fifo_ready_i = 1'b1;
  logic              busy_o, tile_done_o, done_o;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0]       stall_cycles_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  weight_tile_fetcher #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .W_DIM_i(W_DIM_i),
    .base_addr_i(base_addr_i), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o),
    .fifo_ready_i(fifo_ready_i), .busy_o(busy_o), .tile_done_o(tile_done_o), .done_o(done_o)
`ifdef WEIGHT_FETCH_PERF_EN
    , .stall_cycles_o(stall_cycles_o)
`endif
  );

  always @(posedge clk_i) if (mem_rd_en_o) mem_rdata_i <= {16{mem_addr_o}};

  int          cyc = 0;
  logic [15:0] addr_q[$];
  logic [15:0] hs_q[$];
  int          hs_cyc[$];
  int          tile_cnt = 0, done_cnt = 0, done_cyc = -1, max_out = 0, hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk_i) begin
    cyc++;
    if (prev_stall && (!fifo_valid_o || fifo_data_o !== prev_data)) hold_err++;
    prev_stall = fifo_valid_o && !fifo_ready_i;
    prev_data  = fifo_data_o;
    if (mem_rd_en_o) addr_q.push_back(mem_addr_o);
    if (fifo_valid_o && fifo_ready_i) begin
      hs_q.push_back(fifo_data_o[15:0]);
      hs_cyc.push_back(cyc);
    end
    if (tile_done_o) tile_cnt++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (addr_q.size() - hs_q.size() > max_out) max_out = addr_q.size() - hs_q.size();
  end

  function automatic int seq_errs(input logic [15:0] q[$], input logic [15:0] first, input int n);
    int bad = (q.size() != n) ? 1 : 0;
    logic [15:0] e = first;
    for (int i = 0; i < n && i < q.size(); i++) begin
      if (q[i] !== e) bad++;
      e = e + 16'd1;
    end
    return bad;
  endfunction

  task automatic clear_mon();
    addr_q.delete();
    hs_q.delete();
    hs_cyc.delete();
    tile_cnt = 0; done_cnt = 0; done_cyc = -1; max_out = 0; hold_err = 0;
  endtask

  task automatic start_job(input logic [8:0] w, input logic [15:0] b);
    @(posedge clk_i); #1;
    W_DIM_i = w; base_addr_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({mem_rd_en_o, fifo_valid_o, busy_o, tile_done_o, done_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd=%b vld=%b busy=%b td=%b done=%b want all 0",
               mem_rd_en_o, fifo_valid_o, busy_o, tile_done_o, done_o);
    end
    checks++;
    if (fifo_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", fifo_data_o[31:0]);
    end
`ifdef WEIGHT_FETCH_PERF_EN
    checks++;
    if (stall_cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall_cycles_o);
    end
`endif
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_tile();
    clear_mon();
    start_job(9'd31, 16'h0100);
    @(negedge clk_i);
    checks++;
    if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 16'h0100 || fifo_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL lat_rd: got rd=%b addr=%h vld=%b busy=%b want 1 0100 0 1",
               mem_rd_en_o, mem_addr_o, fifo_valid_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (fifo_valid_o !== 1'b1 || fifo_data_o[15:0] !== 16'h0100) begin
      errors++;
      $display("FAIL lat_vld: got vld=%b data=%h want 1 0100", fifo_valid_o, fifo_data_o[15:0]);
    end
    wait_done("single", 200);
    checks++;
    if (seq_errs(addr_q, 16'h0100, 32) != 0) begin
      errors++;
      $display("FAIL single_addr: got %0d reads first=%h want 32 from 0100", addr_q.size(), addr_q[0]);
    end
    checks++;
    if (seq_errs(hs_q, 16'h0100, 32) != 0) begin
      errors++;
      $display("FAIL single_rows: got %0d handshakes want 32 in order from 0100", hs_q.size());
    end
    checks++;
    if (tile_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_pulses: got tile_done=%0d done=%0d want 1 1", tile_cnt, done_cnt);
    end
    checks++;
    if (done_cyc != hs_cyc[31] + 1 || hs_cyc[31] - hs_cyc[0] != 31) begin
      errors++;
      $display("FAIL single_timing: got done@%0d last_hs@%0d first_hs@%0d want done=last+1, span 31",
               done_cyc, hs_cyc[31], hs_cyc[0]);
    end
  endtask

  task automatic test_multi_tile();
    clear_mon();
    start_job(9'd63, 16'h0000);
    wait_done("multi", 400);
    checks++;
    if (seq_errs(addr_q, 16'h0000, 128) != 0 || addr_q[32] !== 16'h0020 || addr_q[64] !== 16'h0040) begin
      errors++;
      $display("FAIL multi_addr: got n=%0d a32=%h a64=%h want 128 0020 0040", addr_q.size(), addr_q[32], addr_q[64]);
    end
    checks++;
    if (seq_errs(hs_q, 16'h0000, 128) != 0) begin
      errors++;
      $display("FAIL multi_rows: got %0d handshakes want 128 in order", hs_q.size());
    end
    checks++;
    if (tile_cnt != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL multi_pulses: got tile_done=%0d done=%0d want 4 1", tile_cnt, done_cnt);
    end
    checks++;
    if (hs_cyc[127] - hs_cyc[0] != 127 || done_cyc != hs_cyc[127] + 1) begin
      errors++;
      $display("FAIL multi_throughput: got span=%0d done-last=%0d want 127 1",
               hs_cyc[127] - hs_cyc[0], done_cyc - hs_cyc[127]);
    end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    start_job(9'd63, 16'h0000);
    repeat (20) @(negedge clk_i);
    @(posedge clk_i); #1;
    start_i = 1'b1; W_DIM_i = 9'd31; base_addr_i = 16'h0500;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("ignored", 400);
    repeat (5) @(negedge clk_i);
    checks++;
    if (seq_errs(hs_q, 16'h0000, 128) != 0 || seq_errs(addr_q, 16'h0000, 128) != 0) begin
      errors++;
      $display("FAIL ignored_rows: got reads=%0d rows=%0d want 128 128 from 0000", addr_q.size(), hs_q.size());
    end
    checks++;
    if (done_cnt != 1 || tile_cnt != 4 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignored_pulses: got done=%0d tile_done=%0d busy=%b want 1 4 0", done_cnt, tile_cnt, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int rd_during = 0;
    clear_mon();
    start_job(9'd31, 16'h0200);
    repeat (10) @(negedge clk_i);
    @(posedge clk_i); #1;
    fifo_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (mem_rd_en_o !== 1'b0 || fifo_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_stop: got rd=%b vld=%b want 0 1", mem_rd_en_o, fifo_valid_o);
    end
    rd_during = addr_q.size();
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    fifo_ready_i = 1'b1;
    wait_done("bp", 200);
    checks++;
    if (max_out > 2 || hold_err != 0) begin
      errors++;
      $display("FAIL bp_skid: got outstanding=%0d hold_errors=%0d want <=2 0", max_out, hold_err);
    end
    checks++;
    if (seq_errs(hs_q, 16'h0200, 32) != 0 || seq_errs(addr_q, 16'h0200, 32) != 0) begin
      errors++;
      $display("FAIL bp_rows: got reads=%0d rows=%0d want 32 32 in order from 0200 (reads at stall %0d)",
               addr_q.size(), hs_q.size(), rd_during);
    end
    checks++;
    if (done_cnt != 1 || tile_cnt != 1) begin
      errors++;
      $display("FAIL bp_pulses: got done=%0d tile_done=%0d want 1 1", done_cnt, tile_cnt);
    end
`ifdef WEIGHT_FETCH_PERF_EN
    checks++;
    if (stall_cycles_o !== 32'd5) begin
      errors++;
      $display("FAIL bp_stall: got %0d want 5", stall_cycles_o);
    end
`endif
  endtask

  task automatic test_reset_midjob();
    int n = 0;
    clear_mon();
    start_job(9'd63, 16'h0000);
    while (hs_q.size() < 40 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (hs_q.size() < 40) begin
      errors++;
      $display("FAIL midrst_reach: got %0d rows want 40", hs_q.size());
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en_o, fifo_valid_o, busy_o, tile_done_o, done_o} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got rd=%b vld=%b busy=%b td=%b done=%b want all 0",
               mem_rd_en_o, fifo_valid_o, busy_o, tile_done_o, done_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (done_cnt != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got done=%0d busy=%b want 0 0", done_cnt, busy_o);
    end
    clear_mon();
    start_job(9'd31, 16'h0300);
    wait_done("midrst", 200);
    checks++;
    if (seq_errs(addr_q, 16'h0300, 32) != 0 || seq_errs(hs_q, 16'h0300, 32) != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_restart: got reads=%0d first=%h rows=%0d done=%0d want 32 0300 32 1",
               addr_q.size(), addr_q[0], hs_q.size(), done_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    clear_mon();
    start_job(9'd31, 16'hFFF0);
    repeat (8) @(negedge clk_i);
    @(posedge clk_i); #1;
    fifo_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1;
    fifo_ready_i = 1'b1;
    wait_done("wrap", 200);
    checks++;
    if (addr_q[15] !== 16'hFFFF || addr_q[16] !== 16'h0000 || addr_q[31] !== 16'h000F) begin
      errors++;
      $display("FAIL wrap_edges: got a15=%h a16=%h a31=%h want FFFF 0000 000F", addr_q[15], addr_q[16], addr_q[31]);
    end
    checks++;
    if (seq_errs(addr_q, 16'hFFF0, 32) != 0 || seq_errs(hs_q, 16'hFFF0, 32) != 0) begin
      errors++;
      $display("FAIL wrap_seq: got reads=%0d rows=%0d want 32 32 from FFF0", addr_q.size(), hs_q.size());
    end
`ifdef WEIGHT_FETCH_PERF_EN
    checks++;
    if (stall_cycles_o !== 32'd3) begin
      errors++;
      $display("FAIL wrap_stall: got %0d want 3", stall_cycles_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_start_ignored();
    test_backpressure();
    test_reset_midjob();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
